// File: rtl/nav_arbiter.sv
// Arbitrates the shared navigate unit between the maze solver and the command
// processor, with per-requester pending slots and a sticky move watchdog.
module nav_arbiter #(
  parameter int unsigned TMO_W   = 26,
  parameter int unsigned TMO_CYC = 50_000_000,
  localparam int unsigned HDNG_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_md,
  input  logic              sol_strt_hdng,
  input  logic              sol_strt_mv,
  input  logic [HDNG_W-1:0] sol_hdng,
  input  logic              cmd_strt_hdng,
  input  logic              cmd_strt_mv,
  input  logic [HDNG_W-1:0] cmd_hdng,
  input  logic              nav_mv_cmplt,
  input  logic              clr_err,
  output logic              nav_strt_hdng,
  output logic              nav_strt_mv,
  output logic [HDNG_W-1:0] nav_hdng,
  output logic              sol_mv_cmplt,
  output logic              cmd_mv_cmplt,
  output logic              owner,
  output logic              busy,
  output logic              tmo_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  typedef struct packed {
    logic              vld;
    logic              is_mv;
    logic [HDNG_W-1:0] hdng;
  } slot_t;

  state_e            state_q, state_d;
  slot_t             sol_q, sol_d, cmd_q, cmd_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic              strt_hdng_q, strt_hdng_d, strt_mv_q, strt_mv_d;
  logic [HDNG_W-1:0] hdng_q, hdng_d;
  logic              sol_cmplt_q, sol_cmplt_d, cmd_cmplt_q, cmd_cmplt_d;
  logic              owner_q, owner_d, busy_q, busy_d, tmo_err_q, tmo_err_d;
  logic              gnt_cmd, gnt_sol, gnt_mv;
  logic [HDNG_W-1:0] gnt_hdng;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sol_q       <= '0;
      cmd_q       <= '0;
      cnt_q       <= '0;
      strt_hdng_q <= 1'b0;
      strt_mv_q   <= 1'b0;
      hdng_q      <= '0;
      sol_cmplt_q <= 1'b0;
      cmd_cmplt_q <= 1'b0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sol_q       <= sol_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      strt_hdng_q <= strt_hdng_d;
      strt_mv_q   <= strt_mv_d;
      hdng_q      <= hdng_d;
      sol_cmplt_q <= sol_cmplt_d;
      cmd_cmplt_q <= cmd_cmplt_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sol_d       = sol_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    strt_hdng_d = 1'b0;
    strt_mv_d   = 1'b0;
    hdng_d      = hdng_q;
    sol_cmplt_d = 1'b0;
    cmd_cmplt_d = 1'b0;
    owner_d     = owner_q;
    tmo_err_d   = clr_err ? 1'b0 : tmo_err_q;
    gnt_cmd     = 1'b0;
    gnt_sol     = 1'b0;
    gnt_mv      = 1'b0;
    gnt_hdng    = '0;

    case (state_q)
      IDLE: begin
        // Command slot has priority; a faulted arbiter holds all requests.
        if (!tmo_err_q) begin
          gnt_cmd = cmd_q.vld;
          gnt_sol = !cmd_q.vld && sol_q.vld && !cmd_md;
        end
        if (gnt_cmd || gnt_sol) begin
          gnt_mv   = gnt_cmd ? cmd_q.is_mv : sol_q.is_mv;
          gnt_hdng = gnt_cmd ? cmd_q.hdng : sol_q.hdng;
          owner_d  = gnt_cmd;
          if (!gnt_mv) hdng_d = gnt_hdng;
          strt_hdng_d = !gnt_mv;
          strt_mv_d   = gnt_mv;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + TMO_W'(1);
        // Completion beats a coincident timeout; either way the owner is released.
        if (nav_mv_cmplt || cnt_q == TMO_W'(TMO_CYC - 1)) begin
          if (!nav_mv_cmplt) tmo_err_d = 1'b1;
          sol_cmplt_d = !owner_q;
          cmd_cmplt_d = owner_q;
          state_d     = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (gnt_cmd) begin
      cmd_d.vld = 1'b0;
    end else if (!cmd_q.vld && (cmd_strt_hdng || cmd_strt_mv)) begin
      cmd_d.vld   = 1'b1;
      cmd_d.is_mv = !cmd_strt_hdng;
      cmd_d.hdng  = cmd_hdng;
    end

    // Command mode flushes and blocks the solver slot.
    if (cmd_md || gnt_sol) begin
      sol_d.vld = 1'b0;
    end else if (!sol_q.vld && (sol_strt_hdng || sol_strt_mv)) begin
      sol_d.vld   = 1'b1;
      sol_d.is_mv = !sol_strt_hdng;
      sol_d.hdng  = sol_hdng;
    end

    busy_d = (state_d != IDLE);
  end

  assign nav_strt_hdng = strt_hdng_q;
  assign nav_strt_mv   = strt_mv_q;
  assign nav_hdng      = hdng_q;
  assign sol_mv_cmplt  = sol_cmplt_q;
  assign cmd_mv_cmplt  = cmd_cmplt_q;
  assign owner         = owner_q;
  assign busy          = busy_q;
  assign tmo_err       = tmo_err_q;

endmodule

// File: doc/nav_arbiter.md
Name: nav_arbiter

Overview:
- Shares the single navigate unit (heading controller plus forward-move engine) between two requesters: the autonomous maze solver and the serial command processor.
- Captures one-cycle start pulses from each requester and grants the navigate unit to one owner at a time.
- Forwards the start pulse and desired heading, waits for move-complete, and returns a completion pulse to the owner only.
- Includes a move watchdog with a sticky timeout fault.

Parameters:
TMO_W, 26, width of watchdog counter
TMO_CYC, 50_000_000, cycles allowed in WAIT before timeout (1 s at 50 MHz); must be ≤ 2^TMO_W-1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
cmd_md  in  1  1 = command mode (solver disabled), 0 = solve mode
sol_strt_hdng  in  1  solver heading-change request pulse
sol_strt_mv  in  1  solver forward-move request pulse
sol_hdng  in  12  solver desired heading, valid with sol_strt_hdng
cmd_strt_hdng  in  1  command heading request pulse
cmd_strt_mv  in  1  command forward-move request pulse
cmd_hdng  in  12  command desired heading, valid with cmd_strt_hdng
nav_mv_cmplt  in  1  navigate unit done pulse
clr_err  in  1  clears tmo_err
nav_strt_hdng  out  1  heading start pulse to navigate unit
nav_strt_mv  out  1  move start pulse to navigate unit
nav_hdng  out  12  registered desired heading to navigate unit
sol_mv_cmplt  out  1  completion pulse to solver
cmd_mv_cmplt  out  1  completion pulse to command processor
owner  out  1  current/last grant: 0 solver, 1 command
busy  out  1  high in ISSUE, WAIT, DONE
tmo_err  out  1  sticky watchdog fault

Behaviour:
- Reset: all outputs 0, nav_hdng=12'h000, both pending slots empty, counter 0, state IDLE.
- Pending slot per requester: valid bit, type bit (hdng/mv), 12-bit heading. Slot loads on a request pulse when empty; a pulse arriving while the slot is full is dropped.
- Same-cycle strt_hdng and strt_mv from one requester: hdng is captured, mv is dropped.
- Move requests do not change the captured heading; nav_hdng holds its previous value.
- Solver pulses are ignored while cmd_md=1. Any cmd_md=1 cycle clears the solver slot. An in-flight solver grant still completes normally.
- FSM states:
  - IDLE: if tmo_err=1, stay. Else if cmd slot valid: grant cmd (owner=1). Else if sol slot valid: grant solver (owner=0). On grant, load nav_hdng if type=hdng, clear the granted slot, go to ISSUE.
  - ISSUE: assert nav_strt_hdng or nav_strt_mv (per type) for exactly 1 cycle; clear counter; go to WAIT.
  - WAIT: counter increments each cycle. On nav_mv_cmplt, go to DONE. Else if counter==TMO_CYC-1, set tmo_err and go to DONE.
  - DONE: pulse owner's *_mv_cmplt for 1 cycle, also on timeout so the requester never hangs; go to IDLE.
- Priority: command beats solver when both slots are valid in IDLE. Grants are never preempted.
- Latency:
  - Request pulse in cycle N → slot valid in N+1 → nav_strt_* high in N+2 if IDLE.
  - nav_mv_cmplt in cycle M (WAIT) → owner cmplt high in M+1 → IDLE in M+2.
  - Back-to-back requests issue every 4+ cycles.
- nav_mv_cmplt outside WAIT is ignored.
- nav_mv_cmplt and timeout in the same cycle: completion wins, tmo_err is not set.
- clr_err clears tmo_err next edge. Timeout and clr_err in the same cycle: tmo_err is set.
- Slots keep accepting requests while busy or faulted.
- rst mid-operation: immediate return to IDLE, slots cleared, no completion pulse issued.

Test Plan:
- Solver path: cmd_md=0, sol_strt_hdng with sol_hdng=12'h3FF in cycle 10 → nav_hdng=12'h3FF and nav_strt_hdng high in cycle 12 only. nav_mv_cmplt in cycle 20 → sol_mv_cmplt high in cycle 21 only; cmd_mv_cmplt stays 0.
- Priority: cmd_strt_mv and sol_strt_hdng (12'h7FF) in the same cycle while IDLE → cmd move issued first (owner=1, nav_hdng unchanged). After its completion, solver heading issued with nav_hdng=12'h7FF.
- Mode gating: cmd_md=1 with sol_strt_mv → no nav_strt_mv, slot stays empty. Solver pending, then cmd_md 0→1 before grant (grant blocked by busy) → solver request discarded.
- Watchdog: TMO_CYC=16, issue a move, never complete → tmo_err=1 after 16 WAIT cycles, then owner cmplt pulses. Further requests are held until clr_err, then issued.
- Drop and tie rules: second cmd_strt_hdng while cmd slot full → dropped, only one issue. nav_mv_cmplt on the terminal timeout cycle → tmo_err remains 0.
- Reset: assert rst during WAIT → all outputs 0 asynchronously, no completion pulse. After release, a new request is served normally.
